// File: rtl/servant_rst_pkg.sv
// rtl/servant_rst_pkg.sv - state encodings and constants shared by the servant reset sequencer
package servant_rst_pkg;

   localparam logic [1:0] ENC_LOCK_WAIT = 2'd0;
   localparam logic [1:0] ENC_HOLD      = 2'd1;
   localparam logic [1:0] ENC_RUN       = 2'd2;

   typedef enum logic [1:0] {
      LOCK_WAIT = ENC_LOCK_WAIT,
      HOLD      = ENC_HOLD,
      RUN       = ENC_RUN
   } rst_state_t;

   localparam logic [7:0] RST_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/servant_sync2.sv
// rtl/servant_sync2.sv - generic two-flop synchroniser with asynchronous active-low clear
module servant_sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/servant_rst_ctrl.sv
// rtl/servant_rst_ctrl.sv - reset/boot sequencer for the servant core; SERVANT_RST_WDT_EN builds the heartbeat watchdog
module servant_rst_ctrl
   import servant_rst_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = 16,
   parameter int unsigned HOLD_CYCLES = 32,
   parameter logic [31:0] WDT_CYCLES  = 32'd16777216
) (
   input  logic       wb_clk,
   input  logic       wb_rst_n,
   input  logic       i_locked,
   input  logic       i_heartbeat,
   input  logic       i_sw_rst,
   output logic       o_cpu_rst,
   output logic [1:0] o_state,
   output logic       o_wdt_fired,
   output logic [7:0] o_rst_count
);

   localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

   rst_state_t  r_state;
   rst_state_t  w_state_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic        w_locked_s;
   logic        w_wdt_expire;
   logic        w_run_exit;
   logic        w_wdt_exit;
   logic        r_cpu_rst;
   logic        r_wdt_fired;
   logic [7:0]  r_rst_count;

   servant_sync2 #(
      .WIDTH (1)
   ) u_lock_sync (
      .i_clk   (wb_clk),
      .i_rst_n (wb_rst_n),
      .i_d     (i_locked),
      .o_q     (w_locked_s)
   );

`ifdef SERVANT_RST_WDT_EN
   localparam logic [31:0] WDT_LAST = WDT_CYCLES - 32'd1;

   logic        r_hb_d;
   logic [31:0] r_wdt_cnt;
   logic        w_hb_edge;

   assign w_hb_edge    = i_heartbeat ^ r_hb_d;
   // a heartbeat edge on the expiry cycle still counts as alive
   assign w_wdt_expire = (r_state == RUN) && !w_hb_edge && (r_wdt_cnt == WDT_LAST);

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_hb_d    <= 1'b0;
         r_wdt_cnt <= '0;
      end else begin
         r_hb_d <= i_heartbeat;
         if ((r_state != RUN) || (w_state_nxt != RUN) || w_hb_edge) begin
            r_wdt_cnt <= '0;
         end else begin
            r_wdt_cnt <= r_wdt_cnt + 32'd1;
         end
      end
   end
`else
   logic [32:0] w_unused;

   assign w_unused     = {i_heartbeat, WDT_CYCLES};
   assign w_wdt_expire = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_run_exit  = 1'b0;
      w_wdt_exit  = 1'b0;
      case (r_state)
         LOCK_WAIT: begin
            if (!w_locked_s) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == LOCK_LAST) begin
               w_state_nxt = HOLD;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         HOLD: begin
            if (!w_locked_s) begin
               w_state_nxt = LOCK_WAIT;
               w_cnt_nxt   = '0;
            end else if (r_cnt == HOLD_LAST) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         RUN: begin
            w_cnt_nxt = '0;
            if (!w_locked_s) begin
               w_state_nxt = LOCK_WAIT;
               w_run_exit  = 1'b1;
            end else if (w_wdt_expire) begin
               w_state_nxt = HOLD;
               w_run_exit  = 1'b1;
               w_wdt_exit  = 1'b1;
            end else if (i_sw_rst) begin
               w_state_nxt = HOLD;
               w_run_exit  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = LOCK_WAIT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // cpu reset tracks the next state so it changes on the same edge as the FSM
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_state     <= LOCK_WAIT;
         r_cnt       <= '0;
         r_cpu_rst   <= 1'b1;
         r_wdt_fired <= 1'b0;
         r_rst_count <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_cpu_rst <= (w_state_nxt != RUN);
         if (w_wdt_exit) begin
            r_wdt_fired <= 1'b1;
         end
         if (w_run_exit && (r_rst_count != RST_COUNT_MAX)) begin
            r_rst_count <= r_rst_count + 8'd1;
         end
      end
   end

   assign o_cpu_rst   = r_cpu_rst;
   assign o_state     = r_state;
   assign o_wdt_fired = r_wdt_fired;
   assign o_rst_count = r_rst_count;

endmodule

// File: doc/servant_rst_ctrl.md
# servant_rst_ctrl

Reset and boot sequencer for the servant SoC. It sits between the PLL and the servant core: it qualifies PLL lock, holds the CPU in reset for a fixed settling period, and then releases it. While the CPU runs, it supervises the CPU through a heartbeat watchdog and a software reset request, and re-sequences the reset on lock loss, watchdog expiry or request.

## Interface
- LOCK_CYCLES, 16: consecutive synchronised lock cycles required before HOLD; range 1..65535.
- HOLD_CYCLES, 32: cycles the CPU reset is held after lock qualification; range 1..65535.
- WDT_CYCLES, 16777216: heartbeat timeout in cycles; range 2..2^32-1.

- wb_clk  in  1  system clock (PLL output).
- wb_rst_n  in  1  asynchronous, active-low reset; one clock; asynchronous assertion, deassertion used as-is (external sync assumed upstream).
- i_locked  in  1  PLL lock, asynchronous to wb_clk.
- i_heartbeat  in  1  CPU GPIO (servant q), wb_clk domain; any edge is a heartbeat.
- i_sw_rst  in  1  single-cycle software reset request, wb_clk domain.
- o_cpu_rst  out  1  active-high reset to servant; registered.
- o_state  out  2  current FSM state (debug/test pins).
- o_wdt_fired  out  1  sticky: watchdog has expired since wb_rst_n.
- o_rst_count  out  8  count of re-sequences since wb_rst_n, saturating at 255.

## Operation
- i_locked passes through a 2-flop synchroniser to give locked_s. All decisions use locked_s.
- FSM states, encoded on o_state:
  - LOCK_WAIT=0
    - Counter increments while locked_s=1 and clears to 0 when locked_s=0.
    - At locked_s=1 with counter==LOCK_CYCLES-1: go to HOLD and clear the counter.
  - HOLD=1
    - locked_s=0: go to LOCK_WAIT and clear the counter.
    - Otherwise the counter increments; at HOLD_CYCLES-1 go to RUN and clear the counter.
  - RUN=2
    - CPU released.
    - Exit priority, highest first:
      1. locked_s=0: go to LOCK_WAIT.
      2. Watchdog expiry: go to HOLD and set o_wdt_fired.
      3. i_sw_rst=1: go to HOLD.
    - Every RUN exit increments o_rst_count (saturating).
  - State 3 is unused. Recovery from it is to LOCK_WAIT.
- Watchdog
  - A 32-bit counter runs only in RUN and clears on entry to RUN.
  - It clears on any change of i_heartbeat versus its one-cycle-delayed copy.
  - If a heartbeat edge and expiry occur in the same cycle, the heartbeat wins and there is no expiry.
  - Expiry occurs when the counter reaches WDT_CYCLES-1 with no edge.
- i_sw_rst is ignored outside RUN.
- o_cpu_rst is 1 in every state except RUN.

## Timing
- Reset values while wb_rst_n=0:
  - state LOCK_WAIT; o_cpu_rst=1; o_state=0; o_wdt_fired=0; o_rst_count=0.
  - All counters 0; synchroniser flops 0.
- Lock latency:
  - locked_s follows i_locked by 2 wb_clk edges.
  - With i_locked held high, o_cpu_rst falls at edge 2+LOCK_CYCLES+HOLD_CYCLES after the first edge sampling i_locked=1.
- Exits from RUN:
  - o_cpu_rst rises on the same edge that leaves RUN, i.e. 1 cycle after i_sw_rst or expiry is sampled.
  - For lock loss, o_cpu_rst rises 3 edges after i_locked falls.
- Re-release: after a sw/wdt exit, the CPU is released again HOLD_CYCLES edges after entering HOLD.
- Mid-operation reset: wb_rst_n assertion at any time immediately forces the reset values, including o_cpu_rst=1.

## Configuration
- SERVANT_RST_WDT_EN defined: the watchdog is present as described.
- Not defined:
  - No watchdog counter or heartbeat register is built.
  - o_wdt_fired is tied 0.
  - i_heartbeat is unused.
  - RUN exits only on lock loss or i_sw_rst.

## Structure
- Package servant_rst_pkg holds:
  - the state enum typedef (LOCK_WAIT, HOLD, RUN);
  - the 2-bit encodings;
  - the o_rst_count saturation constant 8'hFF.
- One sub-module, servant_sync2: a generic 2-flop synchroniser with async active-low clear, used for i_locked.
- The FSM, counters and watchdog live in servant_rst_ctrl.

## Test plan
Bench parameters: LOCK_CYCLES=4, HOLD_CYCLES=8, WDT_CYCLES=64, macro defined unless noted.
- Power-up: wb_rst_n low 3 cycles, then high with i_locked=1 constant -> o_cpu_rst falls exactly 14 edges after the first sample; o_state sequences 0, 1, 2.
- Glitchy lock: i_locked high 3 cycles, low 1 cycle, then high -> qualification restarts; o_cpu_rst falls 14 edges after the final rise; o_rst_count=0.
- Watchdog: in RUN, toggle i_heartbeat every 50 cycles for 500 cycles -> no reset. Then stop toggling -> o_cpu_rst rises 64 cycles after the last edge; o_wdt_fired=1; o_rst_count=1; CPU re-released 8 edges later.
- Soft reset plus saturation: 300 i_sw_rst pulses, each issued in RUN -> each gives 8 cycles of o_cpu_rst=1; o_rst_count ends at 255; o_wdt_fired stays 0.
- Simultaneous events: i_locked falls in the cycle locked_s, expiry and i_sw_rst coincide -> next state LOCK_WAIT; o_rst_count increments by exactly 1.
- Macro undefined: hold i_heartbeat static for 10000 cycles in RUN -> o_cpu_rst stays 0 and o_wdt_fired stays 0.
